// File: rtl/load_store_queue.sv
// In-order load/store queue between the LS reservation station and memory.
// Loads issue at head once addressed; stores issue at head after ROB commit.
module load_store_queue #(
    parameter int ENTRY_BITS = 3,
    parameter int ROB_BITS   = 5
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  logic                rdy_in,
    input  logic                _clear,
    input  logic                _in_valid,
    input  logic [3:0]          _in_type,
    input  logic [ROB_BITS-1:0] _in_rob_id,
    output logic                _lsb_full,
    input  logic                _alu_ready,
    input  logic [ROB_BITS-1:0] _alu_rob_id,
    input  logic [31:0]         _alu_value,
    input  logic                _lsb_rs_ready,
    input  logic [ROB_BITS-1:0] _lsb_rob_id,
    input  logic [31:0]         _lsb_st_value,
    input  logic                _rob_commit,
    input  logic [ROB_BITS-1:0] _rob_commit_id,
    output logic                _mem_req,
    output logic                _mem_we,
    output logic [1:0]          _mem_width,
    output logic [31:0]         _mem_addr,
    output logic [31:0]         _mem_wdata,
    input  logic                _mem_done,
    input  logic [31:0]         _mem_rdata,
    output logic                _cdb_ls_ready,
    output logic [ROB_BITS-1:0] _cdb_ls_rob_id,
    output logic [31:0]         _cdb_ls_value
);
    localparam int DEPTH = 1 << ENTRY_BITS;
    typedef logic [ENTRY_BITS-1:0] ptr_t;
    typedef logic [ENTRY_BITS:0]   cnt_t;
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    logic                vld_q [DEPTH], vld_d [DEPTH];
    logic                st_q  [DEPTH], st_d  [DEPTH];
    logic                zx_q  [DEPTH], zx_d  [DEPTH];
    logic [1:0]          wd_q  [DEPTH], wd_d  [DEPTH];
    logic [ROB_BITS-1:0] rob_q [DEPTH], rob_d [DEPTH];
    logic                aok_q [DEPTH], aok_d [DEPTH];
    logic [31:0]         adr_q [DEPTH], adr_d [DEPTH];
    logic                dok_q [DEPTH], dok_d [DEPTH];
    logic [31:0]         dat_q [DEPTH], dat_d [DEPTH];
    logic                cmt_q [DEPTH], cmt_d [DEPTH];

    ptr_t   head_q, head_d, tail_q, tail_d;
    cnt_t   count_q, count_d, ccnt_q, ccnt_d;
    state_t state_q, state_d;
    logic   flushed_q, flushed_d;

    logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic [1:0]          mem_width_q, mem_width_d;
    logic [31:0]         mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
    logic                op_zx_q, op_zx_d;
    logic [ROB_BITS-1:0] op_rob_q, op_rob_d;
    logic                cdb_rdy_q, cdb_rdy_d;
    logic [ROB_BITS-1:0] cdb_rob_q, cdb_rob_d;
    logic [31:0]         cdb_val_q, cdb_val_d;

    logic full, pop, alloc, head_ok, commit_hit;

    assign full           = (count_q == cnt_t'(DEPTH));
    assign _lsb_full      = full;
    assign _mem_req       = mem_req_q;
    assign _mem_we        = mem_we_q;
    assign _mem_width     = mem_width_q;
    assign _mem_addr      = mem_addr_q;
    assign _mem_wdata     = mem_wdata_q;
    assign _cdb_ls_ready  = cdb_rdy_q;
    assign _cdb_ls_rob_id = cdb_rob_q;
    assign _cdb_ls_value  = cdb_val_q;

    function automatic logic [31:0] ext_load(input logic [1:0] w, input logic z,
                                             input logic [31:0] d);
        case (w)
            2'b00:   return z ? {24'b0, d[7:0]} : {{24{d[7]}}, d[7:0]};
            2'b01:   return z ? {16'b0, d[15:0]} : {{16{d[15]}}, d[15:0]};
            default: return d;
        endcase
    endfunction

    // Next-state: pop/issue, allocate, fill, commit, then flush override
    always_comb begin
        vld_d = vld_q; st_d = st_q; zx_d = zx_q; wd_d = wd_q; rob_d = rob_q;
        aok_d = aok_q; adr_d = adr_q; dok_d = dok_q; dat_d = dat_q; cmt_d = cmt_q;
        head_d = head_q; tail_d = tail_q; count_d = count_q; ccnt_d = ccnt_q;
        state_d = state_q; flushed_d = flushed_q;
        mem_req_d = mem_req_q; mem_we_d = mem_we_q; mem_width_d = mem_width_q;
        mem_addr_d = mem_addr_q; mem_wdata_d = mem_wdata_q;
        op_zx_d = op_zx_q; op_rob_d = op_rob_q;
        cdb_rdy_d = 1'b0; cdb_rob_d = cdb_rob_q; cdb_val_d = cdb_val_q;
        pop = 1'b0;
        commit_hit = 1'b0;
        head_ok = vld_q[head_q] && aok_q[head_q] &&
                  (!st_q[head_q] || (dok_q[head_q] && cmt_q[head_q]));

        if (state_q == S_WAIT) begin
            if (_mem_done) begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                flushed_d = 1'b0;
                if (!flushed_q) begin
                    pop = 1'b1;
                    vld_d[head_q] = 1'b0;
                    cmt_d[head_q] = 1'b0;
                    head_d = head_q + ptr_t'(1);
                    if (mem_we_q) begin
                        ccnt_d = ccnt_q - cnt_t'(1);
                    end else if (!_clear) begin
                        cdb_rdy_d = 1'b1;
                        cdb_rob_d = op_rob_q;
                        cdb_val_d = ext_load(mem_width_q, op_zx_q, _mem_rdata);
                    end
                end
            end else if (_clear && !mem_we_q) begin
                flushed_d = 1'b1;
            end
        end else if (head_ok && (!_clear || cmt_q[head_q])) begin
            state_d     = S_WAIT;
            mem_req_d   = 1'b1;
            mem_we_d    = st_q[head_q];
            mem_width_d = wd_q[head_q];
            mem_addr_d  = adr_q[head_q];
            mem_wdata_d = dat_q[head_q];
            op_zx_d     = zx_q[head_q];
            op_rob_d    = rob_q[head_q];
        end

        alloc = _in_valid && !_clear && (!full || pop);
        if (alloc) begin
            vld_d[tail_q] = 1'b1;
            st_d[tail_q]  = _in_type[3];
            zx_d[tail_q]  = _in_type[2];
            wd_d[tail_q]  = _in_type[1:0];
            rob_d[tail_q] = _in_rob_id;
            aok_d[tail_q] = 1'b0;
            dok_d[tail_q] = 1'b0;
            cmt_d[tail_q] = 1'b0;
            tail_d = tail_q + ptr_t'(1);
        end
        count_d = count_q + cnt_t'(alloc) - cnt_t'(pop);

        for (int i = 0; i < DEPTH; i++) begin
            if (!_clear && _alu_ready && vld_d[i] && rob_d[i] == _alu_rob_id) begin
                aok_d[i] = 1'b1;
                adr_d[i] = _alu_value;
            end
            if (!_clear && _lsb_rs_ready && vld_d[i] && rob_d[i] == _lsb_rob_id) begin
                dok_d[i] = 1'b1;
                dat_d[i] = _lsb_st_value;
            end
            if (_rob_commit && vld_d[i] && st_d[i] && !cmt_d[i] &&
                rob_d[i] == _rob_commit_id) begin
                cmt_d[i] = 1'b1;
                commit_hit = 1'b1;
            end
        end
        if (commit_hit) begin
            ccnt_d = ccnt_d + cnt_t'(1);
        end

        if (_clear) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_d[i] = vld_d[i] && cmt_d[i];
            end
            tail_d  = head_d + ptr_t'(ccnt_d);
            count_d = ccnt_d;
        end
    end

    // State registers; rdy_in low freezes everything
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                vld_q[i] <= 1'b0; st_q[i] <= 1'b0; zx_q[i] <= 1'b0;
                wd_q[i] <= '0; rob_q[i] <= '0; aok_q[i] <= 1'b0;
                adr_q[i] <= '0; dok_q[i] <= 1'b0; dat_q[i] <= '0;
                cmt_q[i] <= 1'b0;
            end
            head_q <= '0; tail_q <= '0; count_q <= '0; ccnt_q <= '0;
            state_q <= S_IDLE; flushed_q <= 1'b0;
            mem_req_q <= 1'b0; mem_we_q <= 1'b0; mem_width_q <= '0;
            mem_addr_q <= '0; mem_wdata_q <= '0;
            op_zx_q <= 1'b0; op_rob_q <= '0;
            cdb_rdy_q <= 1'b0; cdb_rob_q <= '0; cdb_val_q <= '0;
        end else if (rdy_in) begin
            vld_q <= vld_d; st_q <= st_d; zx_q <= zx_d; wd_q <= wd_d;
            rob_q <= rob_d; aok_q <= aok_d; adr_q <= adr_d; dok_q <= dok_d;
            dat_q <= dat_d; cmt_q <= cmt_d;
            head_q <= head_d; tail_q <= tail_d; count_q <= count_d; ccnt_q <= ccnt_d;
            state_q <= state_d; flushed_q <= flushed_d;
            mem_req_q <= mem_req_d; mem_we_q <= mem_we_d; mem_width_q <= mem_width_d;
            mem_addr_q <= mem_addr_d; mem_wdata_q <= mem_wdata_d;
            op_zx_q <= op_zx_d; op_rob_q <= op_rob_d;
            cdb_rdy_q <= cdb_rdy_d; cdb_rob_q <= cdb_rob_d; cdb_val_q <= cdb_val_d;
        end
    end
endmodule

// File: tb/tb_load_store_queue.sv
// Directed bench for load_store_queue.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_load_store_queue;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [3:0]  in_type = '0;
    logic [4:0]  in_rob = '0;
    logic        full;
    logic        alu_rdy = 1'b0;
    logic [4:0]  alu_rob = '0;
    logic [31:0] alu_val = '0;
    logic        rs_rdy = 1'b0;
    logic [4:0]  rs_rob = '0;
    logic [31:0] rs_val = '0;
    logic        commit = 1'b0;
    logic [4:0]  commit_id = '0;
    logic        mem_req, mem_we;
    logic [1:0]  mem_width;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_done = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        cdb_rdy;
    logic [4:0]  cdb_rob;
    logic [31:0] cdb_val;

    int checks = 0;
    int errors = 0;

    localparam logic [3:0] LB = 4'b0000, LBU = 4'b0100, LW = 4'b0010;
    localparam logic [3:0] SB = 4'b1000, SW = 4'b1010;

    always #5 clk = ~clk;

    load_store_queue dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), ._clear(clear),
        ._in_valid(in_valid), ._in_type(in_type), ._in_rob_id(in_rob),
        ._lsb_full(full),
        ._alu_ready(alu_rdy), ._alu_rob_id(alu_rob), ._alu_value(alu_val),
        ._lsb_rs_ready(rs_rdy), ._lsb_rob_id(rs_rob), ._lsb_st_value(rs_val),
        ._rob_commit(commit), ._rob_commit_id(commit_id),
        ._mem_req(mem_req), ._mem_we(mem_we), ._mem_width(mem_width),
        ._mem_addr(mem_addr), ._mem_wdata(mem_wdata),
        ._mem_done(mem_done), ._mem_rdata(mem_rdata),
        ._cdb_ls_ready(cdb_rdy), ._cdb_ls_rob_id(cdb_rob), ._cdb_ls_value(cdb_val)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] t, input logic [4:0] id);
        in_valid = 1'b1; in_type = t; in_rob = id;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic alu(input logic [4:0] id, input logic [31:0] a);
        alu_rdy = 1'b1; alu_rob = id; alu_val = a;
        tick();
        alu_rdy = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!mem_req && n < 20) begin
            tick();
            n++;
        end
        chk(tag, {31'b0, mem_req}, 32'd1);
    endtask

    task automatic done(input logic [31:0] d);
        mem_done = 1'b1; mem_rdata = d;
        tick();
        mem_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [4:0] ids [8];
        logic       seen;
        ids = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17, 5'd19};

        tick();
        tick();
        chk("rst_req", {31'b0, mem_req}, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        chk("rst_cdb", {31'b0, cdb_rdy}, 32'd0);
        rst = 1'b0;

        // 1: LW id3, address one cycle later
        push(LW, 5'd3);
        alu(5'd3, 32'h100);
        chk("t1_req_early", {31'b0, mem_req}, 32'd0);
        tick();
        chk("t1_req", {31'b0, mem_req}, 32'd1);
        chk("t1_addr", mem_addr, 32'h100);
        chk("t1_we", {31'b0, mem_we}, 32'd0);
        chk("t1_width", {30'b0, mem_width}, 32'd2);
        done(32'hDEADBEEF);
        chk("t1_cdb_rdy", {31'b0, cdb_rdy}, 32'd1);
        chk("t1_cdb_rob", {27'b0, cdb_rob}, 32'd3);
        chk("t1_cdb_val", cdb_val, 32'hDEADBEEF);
        chk("t1_req_drop", {31'b0, mem_req}, 32'd0);
        tick();
        chk("t1_cdb_pulse", {31'b0, cdb_rdy}, 32'd0);

        // 2: LB / LBU extension
        push(LB, 5'd1);
        push(LBU, 5'd2);
        alu(5'd1, 32'h0);
        alu(5'd2, 32'h0);
        wait_req("t2_req1");
        chk("t2_width", {30'b0, mem_width}, 32'd0);
        done(32'h80);
        chk("t2_cdb_rob1", {27'b0, cdb_rob}, 32'd1);
        chk("t2_lb", cdb_val, 32'hFFFFFF80);
        wait_req("t2_req2");
        done(32'h80);
        chk("t2_cdb_rob2", {27'b0, cdb_rob}, 32'd2);
        chk("t2_lbu", cdb_val, 32'h00000080);

        // 3: store waits for commit
        push(SW, 5'd4);
        alu_rdy = 1'b1; alu_rob = 5'd4; alu_val = 32'h200;
        rs_rdy = 1'b1; rs_rob = 5'd4; rs_val = 32'h12345678;
        tick();
        alu_rdy = 1'b0; rs_rdy = 1'b0;
        tick(); tick(); tick();
        chk("t3_no_req", {31'b0, mem_req}, 32'd0);
        commit = 1'b1; commit_id = 5'd4;
        tick();
        commit = 1'b0;
        wait_req("t3_req");
        chk("t3_we", {31'b0, mem_we}, 32'd1);
        chk("t3_addr", mem_addr, 32'h200);
        chk("t3_wdata", mem_wdata, 32'h12345678);
        done(32'h0);
        chk("t3_no_cdb", {31'b0, cdb_rdy}, 32'd0);
        tick();
        chk("t3_idle", {31'b0, mem_req}, 32'd0);

        // 4: fill to full, drop 9th, pop+push at full, wrap
        do_reset();
        for (int i = 0; i < 8; i++) push(LW, 5'(10 + i));
        chk("t4_full", {31'b0, full}, 32'd1);
        push(LW, 5'd18);
        chk("t4_full_drop", {31'b0, full}, 32'd1);
        alu(5'd10, 32'h300);
        wait_req("t4_req10");
        mem_done = 1'b1; mem_rdata = 32'hA;
        in_valid = 1'b1; in_type = LW; in_rob = 5'd19;
        tick();
        mem_done = 1'b0; in_valid = 1'b0;
        chk("t4_full_kept", {31'b0, full}, 32'd1);
        chk("t4_cdb10", {27'b0, cdb_rob}, 32'd10);
        for (int i = 0; i < 8; i++) begin
            alu(ids[i], 32'h400 + 32'(i) * 4);
            wait_req("t4_req");
            chk("t4_addr", mem_addr, 32'h400 + 32'(i) * 4);
            done(32'(i));
            chk("t4_cdb_rob", {27'b0, cdb_rob}, {27'b0, ids[i]});
            if (i == 0) chk("t4_not_full", {31'b0, full}, 32'd0);
        end

        // 5: clear keeps committed store, drops younger ops
        push(SW, 5'd5);
        push(LW, 5'd6);
        push(SB, 5'd7);
        alu_rdy = 1'b1; alu_rob = 5'd5; alu_val = 32'h240;
        rs_rdy = 1'b1; rs_rob = 5'd5; rs_val = 32'hCAFE0001;
        tick();
        alu_rdy = 1'b0; rs_rdy = 1'b0;
        alu(5'd6, 32'h500);
        commit = 1'b1; commit_id = 5'd5;
        tick();
        commit = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5_req", {31'b0, mem_req}, 32'd1);
        chk("t5_we", {31'b0, mem_we}, 32'd1);
        chk("t5_addr", mem_addr, 32'h240);
        done(32'h0);
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            seen = seen | mem_req | cdb_rdy;
            tick();
        end
        chk("t5_quiet", {31'b0, seen}, 32'd0);
        push(LW, 5'd8);
        alu(5'd8, 32'h540);
        wait_req("t5_req8");
        chk("t5_addr8", mem_addr, 32'h540);
        done(32'h55);
        chk("t5_cdb8", {27'b0, cdb_rob}, 32'd8);

        // 5b: clear with a load in flight suppresses CDB
        push(LW, 5'd9);
        alu(5'd9, 32'h600);
        wait_req("t5b_req");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t5b_held", {31'b0, mem_req}, 32'd1);
        done(32'h77);
        chk("t5b_no_cdb", {31'b0, cdb_rdy}, 32'd0);
        push(LW, 5'd20);
        alu(5'd20, 32'h640);
        wait_req("t5b_req20");
        chk("t5b_addr20", mem_addr, 32'h640);
        done(32'h1234);
        chk("t5b_cdb20", {27'b0, cdb_rob}, 32'd20);
        chk("t5b_val20", cdb_val, 32'h1234);

        // rdy low: push ignored
        rdy = 1'b0;
        push(LW, 5'd23);
        rdy = 1'b1;
        alu(5'd23, 32'h700);
        tick(); tick();
        chk("rdy_ignored", {31'b0, mem_req}, 32'd0);

        // 6: reset during WAIT
        push(LW, 5'd21);
        alu(5'd21, 32'h800);
        wait_req("t6_req");
        rst = 1'b1;
        #1;
        chk("t6_req0", {31'b0, mem_req}, 32'd0);
        chk("t6_addr0", mem_addr, 32'h0);
        chk("t6_full0", {31'b0, full}, 32'd0);
        tick();
        rst = 1'b0;
        push(LW, 5'd22);
        alu(5'd22, 32'h900);
        tick();
        chk("t6_req22", {31'b0, mem_req}, 32'd1);
        chk("t6_addr22", mem_addr, 32'h900);
        done(32'hFFFF8001);
        chk("t6_cdb22", {27'b0, cdb_rob}, 32'd22);
        chk("t6_val22", cdb_val, 32'hFFFF8001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
